// File: rtl/sbus_pkg.sv
// Shared encodings and defaults for the system-bus arbiter slice.
// Owner codes double as the debug owner_o value.
package sbus_pkg;

    localparam int SBUS_AW = 32;
    localparam int SBUS_DW = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DMEM = 2'd1,
        OWN_IMEM = 2'd2,
        OWN_BG   = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    // A requested beat count of zero still moves one beat.
    function automatic logic [3:0] beat_target(input logic [3:0] burst_cnt);
        return (burst_cnt == 4'd0) ? 4'd1 : burst_cnt;
    endfunction

endpackage

// File: rtl/sbus_prio_sel.sv
// Fixed-priority winner select (dmem > imem > bg) with an override that
// lets a starved bg requester jump the queue.
module sbus_prio_sel
    import sbus_pkg::*;
(
    input  logic   dmem_stb,
    input  logic   imem_stb,
    input  logic   bg_stb,
    input  logic   bg_aged,
    output owner_t winner
);

    always_comb begin
        winner = OWN_NONE;
        if (bg_stb && bg_aged) begin
            winner = OWN_BG;
        end else if (dmem_stb) begin
            winner = OWN_DMEM;
        end else if (imem_stb) begin
            winner = OWN_IMEM;
        end else if (bg_stb) begin
            winner = OWN_BG;
        end
    end

endmodule

// File: rtl/sbus_arbiter.sv
// Grants the AMBA master wrapper to one of dmem/imem/bg for a whole burst
// and routes per-beat ack and read data back to the owning requester.
module sbus_arbiter
    import sbus_pkg::*;
#(
    parameter int AW      = SBUS_AW,
    parameter int DW      = SBUS_DW,
    parameter int AGE_MAX = 8
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          dmem_stb_i,
    input  logic          dmem_we_i,
    input  logic [AW-1:0] dmem_adr_i,
    input  logic [DW-1:0] dmem_dat_i,
    input  logic [3:0]    dmem_sel_i,
    input  logic [3:0]    dmem_burst_cnt_i,
    output logic [DW-1:0] dmem_dat_o,
    output logic          dmem_ack_o,
    input  logic          imem_stb_i,
    input  logic [AW-1:0] imem_adr_i,
    input  logic [3:0]    imem_burst_cnt_i,
    output logic [DW-1:0] imem_dat_o,
    output logic          imem_ack_o,
    input  logic          bg_stb_i,
    input  logic          bg_we_i,
    input  logic [AW-1:0] bg_adr_i,
    input  logic [DW-1:0] bg_dat_i,
    input  logic [3:0]    bg_sel_i,
    input  logic [3:0]    bg_burst_cnt_i,
    output logic [DW-1:0] bg_dat_o,
    output logic          bg_ack_o,
    output logic          wrp_stb_o,
    output logic          wrp_we_o,
    output logic [AW-1:0] wrp_adr_o,
    output logic [DW-1:0] wrp_dat_o,
    output logic [3:0]    wrp_sel_o,
    output logic [3:0]    wrp_burst_cnt_o,
    input  logic [DW-1:0] wrp_dat_i,
    input  logic          wrp_ack_i,
    input  logic          wrp_ack_bus_i,
    output logic [1:0]    owner_o
);

    state_t        state_reg, state_next;
    owner_t        owner_reg, winner;
    logic [3:0]    beat_cnt_reg, bg_age_reg, win_burst;
    logic          busy, grant, final_ack, bg_aged;
    logic [2:0]    owned, ack_vec;
    logic [DW-1:0] dat_hold_reg [3];
    logic [DW-1:0] rd_dat [3];

    assign bg_aged   = (bg_age_reg == 4'(AGE_MAX));
    assign grant     = (state_reg == ST_IDLE) && wrp_ack_bus_i && (winner != OWN_NONE);
    assign final_ack = busy && wrp_ack_i && (beat_cnt_reg <= 4'd1);

    sbus_prio_sel u_prio_sel (
        .dmem_stb (dmem_stb_i),
        .imem_stb (imem_stb_i),
        .bg_stb   (bg_stb_i),
        .bg_aged  (bg_aged),
        .winner   (winner)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant) state_next = ST_BUSY;
            ST_BUSY: if (final_ack) state_next = ST_REL;
            ST_REL:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg == ST_BUSY);
        wrp_stb_o = busy;
    end

    always_comb begin
        win_burst = 4'd0;
        case (winner)
            OWN_DMEM: win_burst = dmem_burst_cnt_i;
            OWN_IMEM: win_burst = imem_burst_cnt_i;
            OWN_BG:   win_burst = bg_burst_cnt_i;
            default:  win_burst = 4'd0;
        endcase
    end

    // Owner is only non-zero while BUSY; it clears on the final beat so REL shows none.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg    <= OWN_NONE;
            beat_cnt_reg <= 4'd0;
        end else if (grant) begin
            owner_reg    <= winner;
            beat_cnt_reg <= beat_target(win_burst);
        end else if (final_ack) begin
            owner_reg    <= OWN_NONE;
            beat_cnt_reg <= 4'd0;
        end else if (busy && wrp_ack_i) begin
            beat_cnt_reg <= beat_cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            bg_age_reg <= 4'd0;
        end else if (!bg_stb_i || (grant && winner == OWN_BG)) begin
            bg_age_reg <= 4'd0;
        end else if (owner_reg != OWN_BG && !bg_aged) begin
            bg_age_reg <= bg_age_reg + 4'd1;
        end
    end

    always_comb begin
        wrp_we_o        = 1'b0;
        wrp_adr_o       = '0;
        wrp_dat_o       = '0;
        wrp_sel_o       = 4'd0;
        wrp_burst_cnt_o = 4'd0;
        case (owner_reg)
            OWN_DMEM: begin
                wrp_we_o        = dmem_we_i;
                wrp_adr_o       = dmem_adr_i;
                wrp_dat_o       = dmem_dat_i;
                wrp_sel_o       = dmem_sel_i;
                wrp_burst_cnt_o = dmem_burst_cnt_i;
            end
            OWN_IMEM: begin
                wrp_adr_o       = imem_adr_i;
                wrp_sel_o       = 4'b1111;
                wrp_burst_cnt_o = imem_burst_cnt_i;
            end
            OWN_BG: begin
                wrp_we_o        = bg_we_i;
                wrp_adr_o       = bg_adr_i;
                wrp_dat_o       = bg_dat_i;
                wrp_sel_o       = bg_sel_i;
                wrp_burst_cnt_o = bg_burst_cnt_i;
            end
            default: ;
        endcase
    end

    // Per-requester return path; non-owners show the last data they were acked with.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ret
            assign owned[gi]   = (owner_reg == owner_t'(2'(gi + 1)));
            assign ack_vec[gi] = busy && owned[gi] && wrp_ack_i;
            assign rd_dat[gi]  = (busy && owned[gi]) ? wrp_dat_i : dat_hold_reg[gi];

            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    dat_hold_reg[gi] <= '0;
                end else if (ack_vec[gi]) begin
                    dat_hold_reg[gi] <= wrp_dat_i;
                end
            end
        end
    endgenerate

    assign dmem_ack_o = ack_vec[0];
    assign imem_ack_o = ack_vec[1];
    assign bg_ack_o   = ack_vec[2];
    assign dmem_dat_o = rd_dat[0];
    assign imem_dat_o = rd_dat[1];
    assign bg_dat_o   = rd_dat[2];
    assign owner_o    = owner_reg;

endmodule
